// File: rtl/divider_pkg.sv
// Shared definitions for the sequential MIPS DIV/DIVU divider: state codes,
// default width and iteration/counter sizing.
package divider_pkg;

    localparam int DIV_WIDTH = 32;
    localparam int DIV_ITERS = DIV_WIDTH;
    localparam int CNT_W     = $clog2(DIV_ITERS);

    typedef logic [1:0] state_t;

    localparam state_t IDLE = 2'd0;
    localparam state_t CALC = 2'd1;
    localparam state_t FIX  = 2'd2;
    localparam state_t DONE = 2'd3;

endpackage

// File: rtl/seq_divider_div_step.sv
// One radix-2 restoring step: shift a dividend bit into the partial remainder,
// trial-subtract the divisor and keep the difference when it does not borrow.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic             bit_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic             q_bit
);

    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] diff;

    // The extra top bit of diff is the borrow out of the WIDTH+1-bit compare.
    always_comb begin
        shifted = {rem_in, bit_in};
        diff    = {1'b0, shifted} - {2'b00, divisor};
        q_bit   = ~diff[WIDTH+1];
        rem_out = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle radix-2 restoring divider for MIPS DIV/DIVU: quotient on Lo,
// remainder on Hi, one quotient bit per clock over the magnitudes.
module seq_divider
    import divider_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid_in,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    output logic             valid_out,
    output logic             busy,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    state_t           state;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] dvs;
    logic             sgn;
    logic             neg_a;
    logic             neg_b;

    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic [WIDTH-1:0] step_rem;
    logic             step_q;

    always_comb begin
        mag_a = (is_signed && SrcA[WIDTH-1]) ? -SrcA : SrcA;
        mag_b = (is_signed && SrcB[WIDTH-1]) ? -SrcB : SrcB;
    end

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_in  (rem),
        .bit_in  (quo[WIDTH-1]),
        .divisor (dvs),
        .rem_out (step_rem),
        .q_bit   (step_q)
    );

    assign valid_out = (state == DONE);
    assign busy      = (state != IDLE);

    // quo starts as the dividend magnitude and fills with quotient bits as it
    // shifts out, so after WIDTH steps it holds the unsigned quotient.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            count       <= '0;
            rem         <= '0;
            quo         <= '0;
            dvs         <= '0;
            sgn         <= 1'b0;
            neg_a       <= 1'b0;
            neg_b       <= 1'b0;
            div_by_zero <= 1'b0;
            Hi          <= '0;
            Lo          <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (valid_in) begin
                        sgn   <= is_signed;
                        neg_a <= is_signed & SrcA[WIDTH-1];
                        neg_b <= is_signed & SrcB[WIDTH-1];
                        quo   <= mag_a;
                        dvs   <= mag_b;
                        rem   <= '0;
                        count <= '0;
                        if (SrcB == '0) begin
                            Lo          <= '1;
                            Hi          <= SrcA;
                            div_by_zero <= 1'b1;
                            state       <= DONE;
                        end else begin
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    rem   <= step_rem;
                    quo   <= {quo[WIDTH-2:0], step_q};
                    count <= count + 1'b1;
                    if (count == LAST_ITER) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    // Truncating negation makes the most-negative / -1 case wrap.
                    Lo          <= (sgn && (neg_a != neg_b)) ? -quo : quo;
                    Hi          <= (sgn && neg_a) ? -rem : rem;
                    div_by_zero <= 1'b0;
                    state       <= DONE;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed corner cases plus randomized
// DIV/DIVU operations compared against a plain-arithmetic reference.
module tb_seq_divider;

    logic        clk;
    logic        rst_n;
    logic        valid_in;
    logic        is_signed;
    logic [31:0] SrcA;
    logic [31:0] SrcB;
    logic        valid_out;
    logic        busy;
    logic        div_by_zero;
    logic [31:0] Hi;
    logic [31:0] Lo;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [31:0] hold_hi;
    logic [31:0] hold_lo;
    logic        hold_z;

    seq_divider #(.WIDTH(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .valid_in    (valid_in),
        .is_signed   (is_signed),
        .SrcA        (SrcA),
        .SrcB        (SrcB),
        .valid_out   (valid_out),
        .busy        (busy),
        .div_by_zero (div_by_zero),
        .Hi          (Hi),
        .Lo          (Lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference: C-style truncating division on sign-extended 64-bit values.
    task automatic model(input logic [31:0] a, input logic [31:0] b, input logic s,
                         output logic [31:0] q, output logic [31:0] r, output logic z);
        longint sa;
        longint sb;
        longint lq;
        longint lr;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
            z = 1'b1;
        end else if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            lq = sa / sb;
            lr = sa % sb;
            q  = lq[31:0];
            r  = lr[31:0];
            z  = 1'b0;
        end else begin
            q = a / b;
            r = a % b;
            z = 1'b0;
        end
    endtask

    // Called just after the acceptance edge; returns at the negedge after DONE.
    task automatic wait_result(input logic [31:0] a, input logic [31:0] b, input logic s,
                               input logic keep, input logic [31:0] na, input logic [31:0] nb,
                               input logic ns, input string tag);
        logic [31:0] eq;
        logic [31:0] er;
        logic        ez;
        int          cyc;
        bit          seen;
        model(a, b, s, eq, er, ez);
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (valid_out) begin
                seen = 1'b1;
            end else if (cyc == 1) begin
                check_output({tag, " busy"}, 32'(busy), 32'd1);
                check_output({tag, " hold_lo"}, Lo, hold_lo);
                check_output({tag, " hold_hi"}, Hi, hold_hi);
                check_output({tag, " hold_z"}, 32'(div_by_zero), 32'(hold_z));
            end else if (cyc == 5) begin
                SrcA      = $urandom;
                SrcB      = $urandom;
                is_signed = 1'($urandom_range(0, 1));
            end
        end
        if (!seen) begin
            check_output({tag, " timeout"}, 32'd0, 32'd1);
            valid_in = 1'b0;
            return;
        end
        check_output({tag, " latency"}, 32'(cyc), (b == 32'd0) ? 32'd1 : 32'd34);
        check_output({tag, " lo"}, Lo, eq);
        check_output({tag, " hi"}, Hi, er);
        check_output({tag, " dbz"}, 32'(div_by_zero), 32'(ez));
        hold_lo = eq;
        hold_hi = er;
        hold_z  = ez;
        if (keep) begin
            SrcA      = na;
            SrcB      = nb;
            is_signed = ns;
        end else begin
            valid_in = 1'b0;
        end
        @(negedge clk);
        check_output({tag, " pulse"}, 32'(valid_out), 32'd0);
        check_output({tag, " idle"}, 32'(busy), 32'd0);
        check_output({tag, " idle_lo"}, Lo, hold_lo);
    endtask

    task automatic apply_stimulus(input logic [31:0] a, input logic [31:0] b, input logic s, input string tag);
        SrcA      = a;
        SrcB      = b;
        is_signed = s;
        valid_in  = 1'b1;
        @(posedge clk);
        wait_result(a, b, s, 1'b0, 32'd0, 32'd0, 1'b0, tag);
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        logic        rs;

        rst_n     = 1'b0;
        valid_in  = 1'b0;
        is_signed = 1'b0;
        SrcA      = '0;
        SrcB      = '0;
        hold_hi   = '0;
        hold_lo   = '0;
        hold_z    = 1'b0;
        repeat (2) @(negedge clk);
        check_output("rst valid_out", 32'(valid_out), 32'd0);
        check_output("rst busy", 32'(busy), 32'd0);
        check_output("rst dbz", 32'(div_by_zero), 32'd0);
        check_output("rst hi", Hi, 32'd0);
        check_output("rst lo", Lo, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        apply_stimulus(32'd100, 32'd7, 1'b0, "divu 100/7");
        apply_stimulus(-32'sd7, 32'd2, 1'b1, "div -7/2");
        apply_stimulus(32'd7, -32'sd2, 1'b1, "div 7/-2");
        apply_stimulus(-32'sd7, -32'sd2, 1'b1, "div -7/-2");
        apply_stimulus(32'hFFFF_FFFF, 32'd1, 1'b0, "divu max/1");
        apply_stimulus(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, "div overflow");
        apply_stimulus(32'd5, 32'd9, 1'b0, "divu 5/9");
        apply_stimulus(32'd1234, 32'd0, 1'b0, "divu 1234/0");
        apply_stimulus(32'd100, 32'd7, 1'b0, "dbz clear");
        apply_stimulus(32'hFFFF_FFF0, 32'd0, 1'b1, "div neg/0");

        // Back-to-back: valid_in stays high through DONE into the next IDLE.
        SrcA      = 32'd1000;
        SrcB      = 32'd33;
        is_signed = 1'b0;
        valid_in  = 1'b1;
        @(posedge clk);
        wait_result(32'd1000, 32'd33, 1'b0, 1'b1, -32'sd50, 32'd6, 1'b1, "b2b first");
        @(posedge clk);
        wait_result(-32'sd50, 32'd6, 1'b1, 1'b0, 32'd0, 32'd0, 1'b0, "b2b second");

        // Reset in the middle of CALC.
        SrcA      = 32'hDEAD_BEEF;
        SrcB      = 32'd17;
        is_signed = 1'b0;
        valid_in  = 1'b1;
        @(posedge clk);
        repeat (10) @(negedge clk);
        #2;
        rst_n    = 1'b0;
        valid_in = 1'b0;
        #1;
        check_output("midrst valid_out", 32'(valid_out), 32'd0);
        check_output("midrst busy", 32'(busy), 32'd0);
        check_output("midrst dbz", 32'(div_by_zero), 32'd0);
        check_output("midrst hi", Hi, 32'd0);
        check_output("midrst lo", Lo, 32'd0);
        hold_hi = '0;
        hold_lo = '0;
        hold_z  = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        apply_stimulus(32'd9, 32'd3, 1'b0, "post-rst 9/3");

        for (int i = 0; i < 40; i++) begin
            ra = $urandom;
            rs = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0:       rb = 32'd0;
                1:       rb = 32'($urandom_range(1, 15));
                2:       rb = -32'($urandom_range(1, 15));
                default: rb = $urandom;
            endcase
            apply_stimulus(ra, rb, rs, "random");
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
